tour_cmd_sequencer: RTL

- Scripted command source upstream of RemoteComm. Replaces hand-driven cmd/snd_cmd stimulus in knight-tour benches and FPGA bring-up.
- Holds up to DEPTH 16-bit commands, e.g. calibrate 16'h0000 or move-west-1 16'h23F1.
- Issues the commands one at a time through RemoteComm's snd_cmd/cmd_snt handshake. After each command it waits for the KnightsTour acknowledge (resp 8'hA5) before sending the next.
- Flags a bad response, a timeout or an abort as an error.

---
 rtl/tour_cmd_sequencer.sv | 93 +++++++++
 1 files changed

// File: rtl/tour_cmd_sequencer.sv
// tour_cmd_sequencer: replays a loaded command script through the snd_cmd/cmd_snt handshake,
// waiting for the acknowledge byte after each command and flagging bad response, timeout or abort.
module tour_cmd_sequencer #(
    parameter int DEPTH = 16,
    parameter int TIMEOUT_CYCLES = 10000000,
    parameter logic [7:0] ACK_CODE = 8'hA5
) (
    input  logic clk,
    input  logic rst,
    input  logic load_en,
    input  logic [15:0] load_data,
    input  logic clear,
    input  logic start,
    input  logic abort,
    output logic [15:0] cmd,
    output logic snd_cmd,
    input  logic cmd_snt,
    input  logic resp_rdy,
    input  logic [7:0] resp,
    output logic full,
    output logic [$clog2(DEPTH):0] count,
    output logic [$clog2(DEPTH):0] idx,
    output logic busy,
    output logic done,
    output logic err,
    output logic [1:0] err_code
);
    localparam int AW = $clog2(DEPTH);
    localparam int W = AW + 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES);
    typedef enum logic [2:0] {IDLE, SEND, WAIT_SNT, WAIT_RESP, DONE_S, ERROR_S} state_t;
    state_t state, state_n;
    logic [15:0] mem [DEPTH];
    logic [TW-1:0] timer;
    logic [AW-1:0] slot_n;
    logic ack, expire, last, wr, clr;
    assign busy = state inside {SEND, WAIT_SNT, WAIT_RESP};
    assign snd_cmd = state == SEND && !abort && !rst;
    assign done = state == DONE_S;
    assign full = count == W'(DEPTH);
    assign wr = state == IDLE && !clear && !start && load_en && !full;
    assign clr = clear && state inside {IDLE, DONE_S, ERROR_S};
    always_comb begin
        ack = resp_rdy && resp == ACK_CODE;
        expire = timer == TW'(TIMEOUT_CYCLES - 1);
        last = idx + W'(1) == count;
        slot_n = state == IDLE ? '0 : idx[AW-1:0] + AW'(1);
        state_n = state;
        case (state)
            IDLE:      state_n = clear ? IDLE : start ? (count == '0 ? DONE_S : SEND) : IDLE;
            SEND:      state_n = abort ? ERROR_S : WAIT_SNT;
            WAIT_SNT:  state_n = abort ? ERROR_S : cmd_snt ? WAIT_RESP : expire ? ERROR_S : WAIT_SNT;
            WAIT_RESP: state_n = abort ? ERROR_S : resp_rdy ? (ack ? (last ? DONE_S : SEND) : ERROR_S)
                               : expire ? ERROR_S : WAIT_RESP;
            default:   state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk)
        if (wr) mem[count[AW-1:0]] <= load_data;
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cmd <= '0;
            count <= '0;
            idx <= '0;
            timer <= '0;
            err <= 1'b0;
            err_code <= 2'b00;
        end else begin
            state <= state_n;
            timer <= busy && state_n == state ? timer + TW'(1) : '0;
            // cmd is loaded on entry to SEND so it is already valid while snd_cmd is high
            if (state_n == SEND) cmd <= mem[slot_n];
            if (clr) begin
                count <= '0;
                idx <= '0;
                err <= 1'b0;
                err_code <= 2'b00;
            end else if (state == IDLE && start && count != '0) begin
                idx <= '0;
                err <= 1'b0;
                err_code <= 2'b00;
            end else if (wr) begin
                count <= count + W'(1);
            end
            if (state == WAIT_RESP && ack && !abort) idx <= idx + W'(1);
            if (state_n == ERROR_S) begin
                err <= 1'b1;
                err_code <= abort ? 2'b11 : (state == WAIT_RESP && resp_rdy) ? 2'b01 : 2'b10;
            end
        end
    end
endmodule
